// File: rtl/ad_ip_jesd204_link_pkg.sv
// Shared definitions for the JESD204 link-layer width packer.
// Holds the packer state encoding and the slot-counter width helper.
package ad_ip_jesd204_link_pkg;

    // Packer states. SEEK is only reachable when start-of-frame alignment is built in.
    localparam logic [0:0] ST_SEEK = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // Width of the slot counter for a given beat ratio (never narrower than one bit).
    function automatic int cnt_width(input int ratio);
        return ($clog2(ratio) < 1) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_link_packer_lane.sv
// One lane of the link packer: slot register array plus the wide output register.
// The output register is loaded with the assembled word including the beat written
// in the same cycle, so the completing beat appears one cycle after it is accepted.
module ad_ip_jesd204_link_packer_lane
    import ad_ip_jesd204_link_pkg::*;
#(
    parameter int IBW   = 32,
    parameter int RATIO = 2,
    parameter int CW    = cnt_width(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [CW-1:0]        wr_slot,
    input  logic [IBW-1:0]       wr_data,
    input  logic                 load_out,
    output logic [IBW*RATIO-1:0] out_data
);

    logic [IBW*RATIO-1:0] slots_q, slots_d;
    logic [IBW*RATIO-1:0] out_q, out_d;

    // Merge the incoming beat into its slot and decide whether the output reloads.
    always_comb begin
        slots_d = slots_q;
        if (wr_en) begin
            slots_d[wr_slot*IBW +: IBW] = wr_data;
        end
        out_d = load_out ? slots_d : out_q;
    end

    // Slot and output storage; reset discards any partial word at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots_q <= '0;
            out_q   <= '0;
        end else begin
            slots_q <= slots_d;
            out_q   <= out_d;
        end
    end

    assign out_data = out_q;

endmodule

// File: rtl/ad_ip_jesd204_link_packer.sv
// JESD204 link-layer width packer: gathers RATIO narrow beats into one wide beat
// per lane, oldest octets in the LSBs, with valid/ready on both sides.
// Optional feature macro: LINK_PACKER_SOF_ALIGN_EN (SEEK state, realignment to
// start-of-frame markers and the realign_count port).
module ad_ip_jesd204_link_packer
    import ad_ip_jesd204_link_pkg::*;
#(
    parameter int NUM_LANES           = 4,
    parameter int OCTETS_PER_BEAT_IN  = 4,
    parameter int RATIO               = 2,
    parameter int OCTETS_PER_BEAT_OUT = OCTETS_PER_BEAT_IN * RATIO
) (
    input  logic                                      link_clk,
    input  logic                                      link_reset,
    input  logic                                      in_link_valid,
    output logic                                      in_link_ready,
    input  logic [OCTETS_PER_BEAT_IN-1:0]             in_link_sof,
    input  logic [NUM_LANES*8*OCTETS_PER_BEAT_IN-1:0] in_link_data,
    output logic                                      out_link_valid,
    input  logic                                      out_link_ready,
    output logic [OCTETS_PER_BEAT_OUT-1:0]            out_link_sof,
`ifdef LINK_PACKER_SOF_ALIGN_EN
    output logic [7:0]                                realign_count,
`endif
    output logic [NUM_LANES*8*OCTETS_PER_BEAT_OUT-1:0] out_link_data
);

    localparam int IBW = 8 * OCTETS_PER_BEAT_IN;
    localparam int OBW = 8 * OCTETS_PER_BEAT_OUT;
    localparam int CW  = cnt_width(RATIO);

`ifdef LINK_PACKER_SOF_ALIGN_EN
    localparam logic [0:0] RESET_STATE = ST_SEEK;
`else
    localparam logic [0:0] RESET_STATE = ST_FILL;
`endif

    logic [0:0]                     state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           out_valid_q, out_valid_d;
    logic [OCTETS_PER_BEAT_OUT-1:0] sof_slots_q, sof_slots_d;
    logic [OCTETS_PER_BEAT_OUT-1:0] out_sof_q, out_sof_d;
`ifdef LINK_PACKER_SOF_ALIGN_EN
    logic [7:0]                     realign_q, realign_d;
`endif

    logic          accept;
    logic          has_sof;
    logic          wr_en;
    logic [CW-1:0] wr_slot;
    logic          complete;

    assign in_link_ready = ~out_valid_q | out_link_ready;
    assign accept        = in_link_valid & in_link_ready;
    assign has_sof       = |in_link_sof;

    // Packing FSM: chooses the slot for each accepted beat and flags word completion.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_slot  = cnt_q;
        complete = 1'b0;
`ifdef LINK_PACKER_SOF_ALIGN_EN
        realign_d = realign_q;
`endif
        case (state_q)
`ifdef LINK_PACKER_SOF_ALIGN_EN
            ST_SEEK: begin
                if (accept && has_sof) begin
                    wr_en   = 1'b1;
                    wr_slot = '0;
                    cnt_d   = CW'(1);
                    state_d = ST_FILL;
                end
            end
`endif
            default: begin
                if (accept) begin
`ifdef LINK_PACKER_SOF_ALIGN_EN
                    if (has_sof && (cnt_q != '0)) begin
                        wr_en     = 1'b1;
                        wr_slot   = '0;
                        cnt_d     = CW'(1);
                        realign_d = (realign_q != 8'hFF) ? realign_q + 8'd1 : realign_q;
                    end else
`endif
                    begin
                        wr_en   = 1'b1;
                        wr_slot = cnt_q;
                        if (cnt_q == CW'(RATIO - 1)) begin
                            cnt_d    = '0;
                            complete = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
        endcase
    end

    // Start-of-frame slots follow the same slot placement as the data lanes.
    always_comb begin
        sof_slots_d = sof_slots_q;
        if (wr_en) begin
            sof_slots_d[wr_slot*OCTETS_PER_BEAT_IN +: OCTETS_PER_BEAT_IN] = in_link_sof;
        end
        out_sof_d   = complete ? sof_slots_d : out_sof_q;
        out_valid_d = complete ? 1'b1 : (out_link_ready ? 1'b0 : out_valid_q);
    end

    // Control, sof and output-valid state.
    always_ff @(posedge link_clk or posedge link_reset) begin
        if (link_reset) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            sof_slots_q <= '0;
            out_sof_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            sof_slots_q <= sof_slots_d;
            out_sof_q   <= out_sof_d;
        end
    end

`ifdef LINK_PACKER_SOF_ALIGN_EN
    // Saturating count of discarded partial words.
    always_ff @(posedge link_clk or posedge link_reset) begin
        if (link_reset) begin
            realign_q <= '0;
        end else begin
            realign_q <= realign_d;
        end
    end

    assign realign_count = realign_q;
`endif

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            ad_ip_jesd204_link_packer_lane #(
                .IBW   (IBW),
                .RATIO (RATIO),
                .CW    (CW)
            ) u_lane (
                .clk      (link_clk),
                .rst      (link_reset),
                .wr_en    (wr_en),
                .wr_slot  (wr_slot),
                .wr_data  (in_link_data[IBW*i +: IBW]),
                .load_out (complete),
                .out_data (out_link_data[OBW*i +: OBW])
            );
        end
    endgenerate

    assign out_link_valid = out_valid_q;
    assign out_link_sof   = out_sof_q;

endmodule

// File: tb/tb_ad_ip_jesd204_link_packer.sv
// Testbench for ad_ip_jesd204_link_packer.
// Two instances share clock and reset: A (1 lane, 4 octets, RATIO 2) and
// B (2 lanes, 4 octets, RATIO 4). Expected words are queued when stimulus is
// issued and popped by per-instance monitors whenever an output beat transfers.
// Build with LINK_PACKER_SOF_ALIGN_EN defined to also cover seek and realign.
module tb_ad_ip_jesd204_link_packer;

    logic link_clk;
    logic link_reset;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]  a_in_sof;
    logic [31:0] a_in_data;
    logic [7:0]  a_out_sof;
    logic [63:0] a_out_data;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]   b_in_sof;
    logic [63:0]  b_in_data;
    logic [15:0]  b_out_sof;
    logic [255:0] b_out_data;

`ifdef LINK_PACKER_SOF_ALIGN_EN
    logic [7:0] a_realign, b_realign;
`endif

    int checks = 0;
    int passes = 0;

    logic [63:0]  a_exp_data[$];
    logic [7:0]   a_exp_sof[$];
    logic [255:0] b_exp_data[$];
    logic [15:0]  b_exp_sof[$];

    ad_ip_jesd204_link_packer #(
        .NUM_LANES(1), .OCTETS_PER_BEAT_IN(4), .RATIO(2)
    ) dut_a (
        .link_clk       (link_clk),
        .link_reset     (link_reset),
        .in_link_valid  (a_in_valid),
        .in_link_ready  (a_in_ready),
        .in_link_sof    (a_in_sof),
        .in_link_data   (a_in_data),
        .out_link_valid (a_out_valid),
        .out_link_ready (a_out_ready),
        .out_link_sof   (a_out_sof),
`ifdef LINK_PACKER_SOF_ALIGN_EN
        .realign_count  (a_realign),
`endif
        .out_link_data  (a_out_data)
    );

    ad_ip_jesd204_link_packer #(
        .NUM_LANES(2), .OCTETS_PER_BEAT_IN(4), .RATIO(4)
    ) dut_b (
        .link_clk       (link_clk),
        .link_reset     (link_reset),
        .in_link_valid  (b_in_valid),
        .in_link_ready  (b_in_ready),
        .in_link_sof    (b_in_sof),
        .in_link_data   (b_in_data),
        .out_link_valid (b_out_valid),
        .out_link_ready (b_out_ready),
        .out_link_sof   (b_out_sof),
`ifdef LINK_PACKER_SOF_ALIGN_EN
        .realign_count  (b_realign),
`endif
        .out_link_data  (b_out_data)
    );

    // 10 ns link clock
    initial begin
        link_clk = 1'b0;
        forever #5 link_clk = ~link_clk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and reports any difference
    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Present one beat to instance A (sel 0) or B (sel 1) and wait until accepted
    task automatic applyStimulus(input int sel, input logic [63:0] data, input logic [3:0] sof);
        int n;
        logic rdy;
        @(negedge link_clk);
        if (sel == 0) begin
            a_in_valid = 1'b1;
            a_in_data  = data[31:0];
            a_in_sof   = sof;
        end else begin
            b_in_valid = 1'b1;
            b_in_data  = data;
            b_in_sof   = sof;
        end
        n = 0;
        forever begin
            #1;
            rdy = (sel == 0) ? a_in_ready : b_in_ready;
            if (rdy) begin
                @(posedge link_clk);
                break;
            end
            @(negedge link_clk);
            n++;
            if (n > 200) begin
                checks++;
                $display("[TB] FAIL accept_timeout: instance %0d got in_link_ready=0 required 1 within 200 cycles", sel);
                break;
            end
        end
    endtask

    // Drop in_link_valid for one cycle
    task automatic idle(input int sel);
        @(negedge link_clk);
        if (sel == 0) a_in_valid = 1'b0;
        else          b_in_valid = 1'b0;
    endtask

    // Wait (bounded) until every queued expectation has been consumed
    task automatic waitDrain();
        int n;
        n = 0;
        while ((a_exp_data.size() != 0 || b_exp_data.size() != 0) && n < 100) begin
            @(negedge link_clk);
            n++;
        end
    endtask

    // Monitor for A: compares each transferred output beat against the queue
    always @(negedge link_clk) begin
        if (!link_reset && a_out_valid && a_out_ready) begin
            if (a_exp_data.size() == 0) begin
                checks++;
                $display("[TB] FAIL a_unexpected: got data %h with no word expected", a_out_data);
            end else begin
                checkOutput("a_data", 256'(a_out_data), 256'(a_exp_data.pop_front()));
                checkOutput("a_sof",  256'(a_out_sof),  256'(a_exp_sof.pop_front()));
            end
        end
    end

    // Monitor for B
    always @(negedge link_clk) begin
        if (!link_reset && b_out_valid && b_out_ready) begin
            if (b_exp_data.size() == 0) begin
                checks++;
                $display("[TB] FAIL b_unexpected: got data %h with no word expected", b_out_data);
            end else begin
                checkOutput("b_data", b_out_data, b_exp_data.pop_front());
                checkOutput("b_sof",  256'(b_out_sof), 256'(b_exp_sof.pop_front()));
            end
        end
    end

    localparam logic [255:0] B_WORD1 =
        256'hB0000003_B0000002_B0000001_B0000000_A0000003_A0000002_A0000001_A0000000;
    localparam logic [255:0] B_WORD2 =
        256'hD0000003_D0000002_D0000001_D0000000_C0000003_C0000002_C0000001_C0000000;

    initial begin
        link_reset  = 1'b1;
        a_in_valid  = 1'b0; a_in_sof = '0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid  = 1'b0; b_in_sof = '0; b_in_data = '0; b_out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge link_clk);
        checkOutput("rst_a_valid", 256'(a_out_valid), 256'(0));
        checkOutput("rst_a_data",  256'(a_out_data),  256'(0));
        checkOutput("rst_a_sof",   256'(a_out_sof),   256'(0));
        checkOutput("rst_b_valid", 256'(b_out_valid), 256'(0));
        checkOutput("rst_b_data",  b_out_data,        256'(0));
        checkOutput("rst_a_ready", 256'(a_in_ready),  256'(1));
`ifdef LINK_PACKER_SOF_ALIGN_EN
        checkOutput("rst_a_realign", 256'(a_realign), 256'(0));
`endif
        link_reset = 1'b0;

`ifdef LINK_PACKER_SOF_ALIGN_EN
        // Seek: beats without sof are discarded
        applyStimulus(0, 64'h33333330, 4'h0);
        applyStimulus(0, 64'h33333331, 4'h0);
        applyStimulus(0, 64'h33333332, 4'h0);
        idle(0);
        repeat (2) @(negedge link_clk);
        checkOutput("seek_no_output", 256'(a_out_valid), 256'(0));
        a_exp_data.push_back(64'h44444441_44444440);
        a_exp_sof.push_back(8'h01);
        applyStimulus(0, 64'h44444440, 4'h1);
        applyStimulus(0, 64'h44444441, 4'h0);
        idle(0);
        waitDrain();
`endif

        // Continuous streaming on A with first-beat latency checks
        a_exp_data.push_back(64'h22222222_11111111);
        a_exp_sof.push_back(8'h01);
        applyStimulus(0, 64'h11111111, 4'h1);
        #1 checkOutput("a_valid_mid_word", 256'(a_out_valid), 256'(0));
        applyStimulus(0, 64'h22222222, 4'h0);
        #1 checkOutput("a_valid_latency", 256'(a_out_valid), 256'(1));
        a_exp_data.push_back(64'hB0B0B0B0_A0A0A0A0);
        a_exp_sof.push_back(8'h01);
        applyStimulus(0, 64'hA0A0A0A0, 4'h1);
        applyStimulus(0, 64'hB0B0B0B0, 4'h0);
`ifndef LINK_PACKER_SOF_ALIGN_EN
        // sof packed verbatim in the second slot
        a_exp_data.push_back(64'hD0D0D0D0_C0C0C0C0);
        a_exp_sof.push_back(8'h81);
        applyStimulus(0, 64'hC0C0C0C0, 4'h1);
        applyStimulus(0, 64'hD0D0D0D0, 4'h8);
`endif
        idle(0);

        // Continuous streaming on B (two lanes, RATIO 4)
        b_exp_data.push_back(B_WORD1); b_exp_sof.push_back(16'h0001);
        b_exp_data.push_back(B_WORD2); b_exp_sof.push_back(16'h0001);
        for (int k = 0; k < 4; k++)
            applyStimulus(1, {32'hB0000000 | k, 32'hA0000000 | k}, (k == 0) ? 4'h1 : 4'h0);
        for (int k = 0; k < 4; k++)
            applyStimulus(1, {32'hD0000000 | k, 32'hC0000000 | k}, (k == 0) ? 4'h1 : 4'h0);
        idle(1);

        // Gapped B input: identical words expected
        b_exp_data.push_back(B_WORD1); b_exp_sof.push_back(16'h0001);
        b_exp_data.push_back(B_WORD2); b_exp_sof.push_back(16'h0001);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, {32'hB0000000 | k, 32'hA0000000 | k}, (k == 0) ? 4'h1 : 4'h0);
            idle(1);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, {32'hD0000000 | k, 32'hC0000000 | k}, (k == 0) ? 4'h1 : 4'h0);
            idle(1);
        end
`ifndef LINK_PACKER_SOF_ALIGN_EN
        b_exp_data.push_back(B_WORD1); b_exp_sof.push_back(16'h0401);
        for (int k = 0; k < 4; k++)
            applyStimulus(1, {32'hB0000000 | k, 32'hA0000000 | k}, (k == 0) ? 4'h1 : ((k == 2) ? 4'h4 : 4'h0));
        idle(1);
`endif
        waitDrain();

        // Backpressure on A: word held stable, input stalled
        @(posedge link_clk); #1 a_out_ready = 1'b0;
        a_exp_data.push_back(64'h5A5A5A51_5A5A5A50);
        a_exp_sof.push_back(8'h01);
        applyStimulus(0, 64'h5A5A5A50, 4'h1);
        applyStimulus(0, 64'h5A5A5A51, 4'h0);
        idle(0);
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_valid_held", 256'(a_out_valid), 256'(1));
            checkOutput("bp_in_ready",   256'(a_in_ready),  256'(0));
            checkOutput("bp_data_held",  256'(a_out_data),  256'(64'h5A5A5A51_5A5A5A50));
            @(negedge link_clk);
        end
        @(posedge link_clk); #1 a_out_ready = 1'b1;
        a_exp_data.push_back(64'h6B6B6B61_6B6B6B60);
        a_exp_sof.push_back(8'h01);
        applyStimulus(0, 64'h6B6B6B60, 4'h1);
        applyStimulus(0, 64'h6B6B6B61, 4'h0);
        idle(0);
        waitDrain();

`ifdef LINK_PACKER_SOF_ALIGN_EN
        // Realign: sof on the second beat drops the partial word
        a_exp_data.push_back(64'h66666661_55555551);
        a_exp_sof.push_back(8'h01);
        applyStimulus(0, 64'h55555550, 4'h1);
        applyStimulus(0, 64'h55555551, 4'h1);
        applyStimulus(0, 64'h66666661, 4'h0);
        idle(0);
        waitDrain();
        checkOutput("realign_count", 256'(a_realign), 256'(1));
`endif

        // Reset while a word is held: valid and data clear asynchronously
        @(posedge link_clk); #1 a_out_ready = 1'b0;
        applyStimulus(0, 64'h77777770, 4'h1);
        applyStimulus(0, 64'h77777771, 4'h0);
        idle(0);
        checkOutput("pre_reset_valid", 256'(a_out_valid), 256'(1));
        #2 link_reset = 1'b1;
        #1 checkOutput("async_rst_valid", 256'(a_out_valid), 256'(0));
        checkOutput("async_rst_data", 256'(a_out_data), 256'(0));
        @(negedge link_clk);
        link_reset  = 1'b0;
        a_out_ready = 1'b1;

        // Reset mid-fill: partial beat must not appear in the next word
        applyStimulus(0, 64'h88888880, 4'h1);
        idle(0);
        #2 link_reset = 1'b1;
        #1 checkOutput("midfill_rst_valid", 256'(a_out_valid), 256'(0));
        @(negedge link_clk);
        link_reset = 1'b0;
        a_exp_data.push_back(64'h99999991_99999990);
        a_exp_sof.push_back(8'h01);
        applyStimulus(0, 64'h99999990, 4'h1);
        applyStimulus(0, 64'h99999991, 4'h0);
        idle(0);
        waitDrain();

        // Every expected word must have been delivered exactly once
        checkOutput("a_queue_empty", 256'(a_exp_data.size()), 256'(0));
        checkOutput("b_queue_empty", 256'(b_exp_data.size()), 256'(0));

        repeat (2) @(negedge link_clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
